mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single main-memory port between the instruction-fetch side and the data-memory side of the pipelined processor. It accepts single-word read requests from fetch and read/write requests from the memory stage, and grants one transaction at a time with data-side priority and a starvation guard for fetch. It tracks the fixed read latency of the backing memory and returns read data to the requester that issued it. It sits between the fetch/memory stages (or their caches) and the main memory module.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- LAT, 2, backing-memory read latency in cycles (legal range 1..7)
- STARVE, 4, consecutive D-grants with I pending after which I wins next contention (1..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- i_req  in  1  fetch read request; held until i_gnt
- i_addr  in  ADDR_W  fetch word address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  DATA_W  fetch read data (registered, holds last value)
- d_req  in  1  data request; held until d_gnt
- d_wr  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle pulse, d_rdata valid (reads only)
- d_rdata  out  DATA_W  data read data (registered, holds last value)
- mem_en  out  1  memory access this cycle
- mem_wr  out  1  write qualifier for mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid exactly LAT cycles after mem_en read
- mem_busy  in  1  memory cannot accept an access this cycle
- busy  out  1  read outstanding (state != IDLE)
- err  out  1  sticky protocol-violation flag

## Operation
- States: IDLE, WAIT. Reset: IDLE, all outputs 0, rdata regs 0x0000, starve counter 0, err 0.
- IDLE: if mem_busy=0 and any req: grant one requester combinationally (gnt, mem_en, mem_wr, mem_addr, mem_wdata driven same cycle). mem_busy=1: no grant, requests wait.
- Arbitration when both request: D wins unless starve counter == STARVE, then I wins. Single requester always wins.
- Starve counter: +1 on each D-grant while i_req=1 (saturates at STARVE); cleared on I-grant or when i_req=0.
- D write grant: stays IDLE; no response pulse; next grant possible next cycle.
- Read grant (I or D): record owner, load latency counter with LAT, go WAIT. No grants in WAIT.
- WAIT: counter decrements each cycle; at counter==1 the edge captures mem_rdata into owner's rdata reg, pulses owner's rvalid for the following cycle, and returns to IDLE.
- mem_wr=0, mem_addr/mem_wdata=0 whenever mem_en=0.
- err set (sticky until reset) when: i_req or d_req drops in a cycle after being high without a gnt; or i_rvalid and d_rvalid would both be 1.

## Timing
- Read granted in cycle T: mem_rdata sampled at end of T+LAT; rvalid=1 and rdata valid in T+LAT+1; arbiter back in IDLE in T+LAT+1, so a new grant may coincide with the rvalid pulse. Read throughput 1 per LAT+1 cycles.
- Write granted in cycle T: next grant in T+1. Back-to-back writes at full rate.
- gnt is combinational from req/mem_busy/state; requester must sample gnt before the edge and drop/change req after it.
- Reset asserted mid-WAIT: immediately IDLE, rvalid not produced, outstanding read discarded; memory response after reset release ignored.

## Test plan
- Reset: rst=0 with reqs active -> all gnt/rvalid/mem_en 0, rdata 0x0000, busy 0, err 0.
- I read, LAT=2: i_req, i_addr=0x0040 at T; mem returns 0xBEEF in T+2 -> i_gnt, mem_en, mem_addr=0x0040 at T; busy T+1..T+2; i_rvalid=1, i_rdata=0xBEEF in T+3 only.
- Contention: i_req and d_req (read 0x0100) together -> d_gnt first; i_gnt in cycle d_rvalid pulses (T+3); responses go to correct owner.
- Starvation, STARVE=4: d_req write streaming every cycle, i_req held -> 4 d_gnt, then i_gnt on 5th cycle, then D resumes.
- mem_busy=1 for 3 cycles with d_req pending -> no gnt, mem_en=0; grant in first cycle mem_busy=0.
- Reset mid-WAIT, then d_req dropped before grant -> no rvalid after reset; err=1 and stays 1 until next reset.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-side, data-side and backing-memory signals around the memory arbiter.
// slave = arbiter view; master = requesters plus memory (the environment).
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_busy;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_busy,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_busy,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch vs data side, data priority with a fetch starvation
// guard, fixed-latency read tracking and per-owner registered read data.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LAT    = 2,
  parameter int STARVE = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus,
  output logic           busy,
  output logic           err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [2:0] LAT_L    = 3'(LAT);
  localparam logic [3:0] STARVE_L = 4'(STARVE);

  logic [0:0]        state_q, state_d;
  logic [2:0]        lat_q, lat_d;
  logic              owner_q, owner_d;   // 1 = data side owns the outstanding read
  logic [3:0]        starve_q, starve_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic              i_pend_q, i_pend_d, d_pend_q, d_pend_d;
  logic              err_q, err_d;

  logic can_grant, pick_i, i_gnt, d_gnt, rd_gnt, done;

  // Grants are combinational so a requester sees acceptance in the same cycle.
  assign can_grant = rst && (state_q == IDLE) && !bus.mem_busy;
  assign pick_i    = bus.i_req && (!bus.d_req || (starve_q == STARVE_L));
  assign i_gnt     = can_grant && pick_i;
  assign d_gnt     = can_grant && bus.d_req && !pick_i;
  assign rd_gnt    = i_gnt || (d_gnt && !bus.d_wr);
  assign done      = (state_q == WAIT) && (lat_q == 3'd1);

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = i_gnt || d_gnt;
  assign bus.mem_wr    = d_gnt && bus.d_wr;
  assign bus.mem_addr  = i_gnt ? bus.i_addr : (d_gnt ? bus.d_addr : '0);
  assign bus.mem_wdata = (d_gnt && bus.d_wr) ? bus.d_wdata : '0;
  assign bus.i_rvalid  = i_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign busy          = (state_q == WAIT);
  assign err           = err_q;

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    if (rd_gnt) begin
      state_d = WAIT;
      lat_d   = LAT_L;
      owner_d = d_gnt;
    end else if (state_q == WAIT) begin
      lat_d = lat_q - 3'd1;
      if (done) state_d = IDLE;
    end

    i_rvalid_d = done && !owner_q;
    d_rvalid_d = done && owner_q;
    if (i_rvalid_d) i_rdata_d = bus.mem_rdata;
    if (d_rvalid_d) d_rdata_d = bus.mem_rdata;

    // Counts data grants that overtook a waiting fetch; saturates at the guard value.
    if (i_gnt || !bus.i_req)
      starve_d = '0;
    else if (d_gnt && (starve_q != STARVE_L))
      starve_d = starve_q + 4'd1;

    i_pend_d = bus.i_req && !i_gnt;
    d_pend_d = bus.d_req && !d_gnt;
    err_d    = err_q || (i_pend_q && !bus.i_req) || (d_pend_q && !bus.d_req)
                     || (i_rvalid_d && d_rvalid_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      owner_q    <= 1'b0;
      starve_q   <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_pend_q   <= 1'b0;
      d_pend_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_pend_q   <= i_pend_d;
      d_pend_q   <= d_pend_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: queue-driven requesters, a latency memory, and a cycle-level
// transaction model checked every negedge, plus directed literal expectations.
module tb_mem_arbiter;
  localparam int AW = 16, DW = 16, LAT = 2, STARVE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, err;
  int   cyc = 0;
  int   npass = 0, ntot = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(LAT), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err(err));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
  endtask

  function automatic logic [15:0] init_val(input logic [9:0] a);
    return (a == 10'h040) ? 16'hBEEF : {6'b101010, a};
  endfunction

  // Backing memory: read data appears exactly LAT cycles after the granting cycle.
  logic [15:0]   mem   [0:1023];
  logic [1023:0] mwr   = '0;
  logic          rd_pend = 1'b0;
  int            rd_due = 0;
  logic [9:0]    rd_a = '0;
  always @(negedge clk) begin
    if (rst && bus.mem_en) begin
      if (bus.mem_wr) begin
        mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
        mwr[bus.mem_addr[9:0]] <= 1'b1;
      end else begin
        rd_pend <= 1'b1;
        rd_due  <= cyc + LAT;
        rd_a    <= bus.mem_addr[9:0];
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (rd_pend && cyc == rd_due) bus.mem_rdata = mwr[rd_a] ? mem[rd_a] : init_val(rd_a);
    else                          bus.mem_rdata = 16'hDEAD;
  end

  // Requester agents: present queue head, pop after it is granted.
  typedef struct packed { logic wr; logic [15:0] a; logic [15:0] wd; } dreq_t;
  logic [15:0] iq[$];
  dreq_t       dq[$];
  logic        agents = 1'b0;
  logic        ig_s, dg_s;
  always begin
    @(negedge clk);
    ig_s = bus.i_gnt;
    dg_s = bus.d_gnt;
    @(posedge clk);
    #1;
    if (agents) begin
      if (ig_s && iq.size() > 0) void'(iq.pop_front());
      if (dg_s && dq.size() > 0) void'(dq.pop_front());
      if (iq.size() > 0) begin bus.i_req = 1'b1; bus.i_addr = iq[0]; end
      else begin bus.i_req = 1'b0; bus.i_addr = '0; end
      if (dq.size() > 0) begin
        bus.d_req = 1'b1; bus.d_wr = dq[0].wr; bus.d_addr = dq[0].a; bus.d_wdata = dq[0].wd;
      end else begin
        bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      end
    end
  end

  // Transaction-level model: arbiter free from cycle m_free; one response booked at m_rc.
  logic        m_rp, m_ro, m_err, m_ip, m_dp;
  int          m_rc, m_free, m_starve;
  logic [15:0] m_rdat, m_ird, m_drd;
  logic [15:0] sh [0:1023];
  logic [1023:0] shw = '0;
  logic        e_ig, e_dg, e_en, e_wr, e_irv, e_drv, e_busy, iw;
  logic [15:0] e_addr, e_wd;
  byte         glog[$];
  int          gcyc[$], irv_cyc[$], drv_cyc[$];

  always @(negedge clk) begin
    if (!rst) begin
      m_rp = 0; m_ro = 0; m_err = 0; m_ip = 0; m_dp = 0; m_rc = 0; m_free = 0;
      m_starve = 0; m_ird = '0; m_drd = '0;
      chk("rst_gnt", {bus.i_gnt, bus.d_gnt, bus.mem_en, bus.mem_wr}, 4'b0);
      chk("rst_rvalid_busy_err", {bus.i_rvalid, bus.d_rvalid, busy, err}, 4'b0);
      chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 32'h0);
    end else begin
      e_irv = m_rp && m_rc == cyc && !m_ro;
      e_drv = m_rp && m_rc == cyc && m_ro;
      if (e_irv) m_ird = m_rdat;
      if (e_drv) m_drd = m_rdat;
      if (m_rp && m_rc == cyc) m_rp = 0;
      e_busy = m_rp;
      e_ig = 0; e_dg = 0;
      if (cyc >= m_free && !bus.mem_busy && (bus.i_req || bus.d_req)) begin
        iw   = bus.i_req && (!bus.d_req || m_starve == STARVE);
        e_ig = iw;
        e_dg = !iw;
      end
      e_en   = e_ig || e_dg;
      e_wr   = e_dg && bus.d_wr;
      e_addr = e_ig ? bus.i_addr : (e_dg ? bus.d_addr : 16'h0);
      e_wd   = e_wr ? bus.d_wdata : 16'h0;

      chk("i_gnt", bus.i_gnt, e_ig);
      chk("d_gnt", bus.d_gnt, e_dg);
      chk("mem_en_wr", {bus.mem_en, bus.mem_wr}, {e_en, e_wr});
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_wdata", bus.mem_wdata, e_wd);
      chk("rvalid", {bus.i_rvalid, bus.d_rvalid}, {e_irv, e_drv});
      chk("i_rdata", bus.i_rdata, m_ird);
      chk("d_rdata", bus.d_rdata, m_drd);
      chk("busy", busy, e_busy);
      chk("err", err, m_err);

      if (bus.i_rvalid) irv_cyc.push_back(cyc);
      if (bus.d_rvalid) drv_cyc.push_back(cyc);
      if (e_en) begin glog.push_back(e_ig ? "I" : "D"); gcyc.push_back(cyc); end
      if (e_wr) begin
        sh[e_addr[9:0]] = e_wd; shw[e_addr[9:0]] = 1'b1;
      end else if (e_en) begin
        m_rp = 1; m_rc = cyc + LAT + 1; m_free = m_rc; m_ro = e_dg;
        m_rdat = shw[e_addr[9:0]] ? sh[e_addr[9:0]] : init_val(e_addr[9:0]);
      end
      if (e_ig || !bus.i_req) m_starve = 0;
      else if (e_dg && m_starve < STARVE) m_starve++;
      m_err = m_err || (m_ip && !bus.i_req) || (m_dp && !bus.d_req);
      m_ip = bus.i_req && !e_ig;
      m_dp = bus.d_req && !e_dg;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    glog.delete(); gcyc.delete(); irv_cyc.delete(); drv_cyc.delete();
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    step();
    while ((iq.size() > 0 || dq.size() > 0 || busy || bus.i_req || bus.d_req) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) chk("idle_timeout", 32'd0, 32'd1);
    step();
    step();
  endtask

  initial begin
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_wr = 0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.mem_busy = 0;

    // Reset with both requests active.
    bus.i_req = 1; bus.d_req = 1; bus.i_addr = 16'h0040; bus.d_addr = 16'h0100;
    step(); step();
    chk("lit_rst_gnt", {bus.i_gnt, bus.d_gnt, bus.mem_en}, 3'b000);
    chk("lit_rst_state", {busy, err, bus.i_rdata}, 18'h0);
    bus.i_req = 0; bus.d_req = 0; bus.i_addr = '0; bus.d_addr = '0;
    step();
    rst = 1; agents = 1;
    step();

    // Single fetch read.
    clear_logs();
    iq.push_back(16'h0040);
    wait_idle(40);
    chk("lit_ird_ngnt", glog.size(), 1);
    chk("lit_ird_lat", irv_cyc.size() > 0 && gcyc.size() > 0 ? irv_cyc[0] - gcyc[0] : -1, LAT + 1);
    chk("lit_ird_data", bus.i_rdata, 16'hBEEF);

    // Contention: data read first, fetch granted in the d_rvalid cycle.
    clear_logs();
    iq.push_back(16'h0080);
    dq.push_back('{wr: 1'b0, a: 16'h0100, wd: 16'h0});
    wait_idle(40);
    chk("lit_cont_order", glog.size() == 2 ? {glog[0], glog[1]} : 16'h0, {8'h44, 8'h49});
    chk("lit_cont_gap", drv_cyc.size() > 0 && gcyc.size() > 1 ? gcyc[1] - drv_cyc[0] : -1, 0);
    chk("lit_cont_ddata", bus.d_rdata, 16'hA900);
    chk("lit_cont_idata", bus.i_rdata, 16'hA880);

    // Starvation guard: four data writes, then the held fetch, then data resumes.
    clear_logs();
    for (int k = 0; k < 6; k++) dq.push_back('{wr: 1'b1, a: 16'(16'h0300 + k), wd: 16'(16'h1000 + k)});
    iq.push_back(16'h0300);
    wait_idle(60);
    chk("lit_stv_n", glog.size(), 7);
    chk("lit_stv_seq", glog.size() == 7 ? {glog[0], glog[1], glog[2], glog[3], 8'h0} : 40'h0,
        {8'h44, 8'h44, 8'h44, 8'h44, 8'h0});
    chk("lit_stv_ipos", glog.size() == 7 ? {glog[4], glog[5], glog[6]} : 24'h0, {8'h49, 8'h44, 8'h44});
    chk("lit_stv_cyc", gcyc.size() == 7 ? {16'(gcyc[4] - gcyc[0]), 16'(gcyc[5] - gcyc[4])} : 32'h0,
        {16'd4, 16'd3});
    chk("lit_stv_idata", bus.i_rdata, 16'h1000);

    // mem_busy stalls a pending data write for three cycles.
    clear_logs();
    bus.mem_busy = 1;
    dq.push_back('{wr: 1'b1, a: 16'h0010, wd: 16'h5555});
    step(); step(); step(); step();
    chk("lit_mbusy_nogrant", glog.size(), 0);
    bus.mem_busy = 0;
    @(negedge clk); #1;
    chk("lit_mbusy_grant", {bus.d_gnt, bus.mem_wr, bus.mem_addr}, {1'b1, 1'b1, 16'h0010});
    wait_idle(20);

    // Reset in the middle of an outstanding read discards it.
    clear_logs();
    dq.push_back('{wr: 1'b0, a: 16'h0200, wd: 16'h0});
    for (int n = 0; n < 20 && !busy; n++) step();
    chk("lit_mid_busy", busy, 1'b1);
    rst = 0;
    step();
    rst = 1;
    repeat (6) step();
    chk("lit_mid_norv", drv_cyc.size() + irv_cyc.size(), 0);
    chk("lit_mid_drdata", bus.d_rdata, 16'h0000);

    // Request withdrawn before grant sets sticky err.
    agents = 0;
    bus.mem_busy = 1; bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 16'h0020;
    step();
    bus.d_req = 0; bus.d_addr = '0;
    step(); step();
    chk("lit_err_set", err, 1'b1);
    bus.mem_busy = 0;
    repeat (3) step();
    chk("lit_err_sticky", err, 1'b1);
    rst = 0;
    step();
    chk("lit_err_clr", err, 1'b0);
    rst = 1;
    step(); step();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time %0t", $time);
    $fatal(1);
  end
endmodule
